// File: rtl/nn_arith_pkg.sv
// Shared types and constants for the NN arithmetic layer (signed divider and friends).
package nn_arith_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH = 8;

   localparam logic [DIV_WIDTH-1:0] MIN_VAL  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
   localparam logic [DIV_WIDTH-1:0] ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/signed_seq_divider_udiv_step.sv
// One restoring division step on unsigned magnitudes: shift in a dividend bit,
// try to subtract the divisor, keep the difference only when it does not go negative.
module udiv_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   p_i,
   input  logic             dvd_bit_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH:0]   p_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;
   logic           ge_s;

   // The compare uses the full partial remainder so its top bit is never silently dropped.
   always_comb begin
      shifted_s = {p_i[WIDTH-1:0], dvd_bit_i};
      ge_s      = ({p_i, dvd_bit_i} >= {2'b00, dvs_i});
      diff_s    = shifted_s - {1'b0, dvs_i};
      if (ge_s) begin
         p_o     = diff_s;
         q_bit_o = 1'b1;
      end else begin
         p_o     = shifted_s;
         q_bit_o = 1'b0;
      end
   end

endmodule

// File: rtl/signed_seq_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes with sign fix-up,
// fixed WIDTH+1 latency from accepted start to the done pulse.
module signed_seq_divider
   import nn_arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             ready_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o,
   output logic             overflow_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

   div_state_e state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   p_q, p_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             ov_q, ov_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dzo_q, dzo_d;
   logic             ovo_q, ovo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_p_s;
   logic             step_q_s;

   udiv_step #(.WIDTH(WIDTH)) u_step (
      .p_i       (p_q),
      .dvd_bit_i (a_q[WIDTH-1]),
      .dvs_i     (dvs_q),
      .p_o       (step_p_s),
      .q_bit_o   (step_q_s)
   );

   // Next-state and datapath: a_q shifts dividend bits out at the top and quotient bits in at the bottom.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      p_d     = p_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dzo_d   = dzo_q;
      ovo_d   = ovo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               qneg_d  = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
               rneg_d  = dividend_i[WIDTH-1];
               a_d     = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
               dvs_d   = divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
               dz_d    = (divisor_i == {WIDTH{1'b0}});
               ov_d    = (dividend_i == MIN_W) && (divisor_i == ONES_W);
               p_d     = {(WIDTH+1){1'b0}};
               cnt_d   = CW'(WIDTH);
               state_d = DIVIDE;
            end else begin
               state_d = IDLE;
            end
         end
         DIVIDE: begin
            p_d   = step_p_s;
            a_d   = {a_q[WIDTH-2:0], step_q_s};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end else begin
               state_d = DIVIDE;
            end
         end
         FINISH: begin
            // Dividing by zero leaves |dividend| in P, so the remainder fix-up already yields the dividend.
            if (dz_q) begin
               quot_d = ONES_W;
               rem_d  = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            end else if (ov_q) begin
               quot_d = MIN_W;
               rem_d  = {WIDTH{1'b0}};
            end else begin
               quot_d = qneg_q ? -a_q : a_q;
               rem_d  = rneg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            end
            dzo_d   = dz_q;
            ovo_d   = ov_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset that discards any operation in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         a_q     <= {WIDTH{1'b0}};
         p_q     <= {(WIDTH+1){1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
         quot_q  <= {WIDTH{1'b0}};
         rem_q   <= {WIDTH{1'b0}};
         dzo_q   <= 1'b0;
         ovo_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         p_q     <= p_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dzo_q   <= dzo_d;
         ovo_q   <= ovo_d;
         done_q  <= done_d;
      end
   end

   assign ready_o     = (state_q == IDLE);
   assign done_o      = done_q;
   assign quotient_o  = quot_q;
   assign remainder_o = rem_q;
   assign div_zero_o  = dzo_q;
   assign overflow_o  = ovo_q;

endmodule

// File: tb/tb_signed_seq_divider.sv
// Randomised self-checking bench for signed_seq_divider against an integer-arithmetic reference.
module tb_signed_seq_divider;
   import nn_arith_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       ready;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_zero;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_done_cyc = 0;

   signed_seq_divider #(.WIDTH(8)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .ready_o     (ready),
      .done_o      (done),
      .quotient_o  (quotient),
      .remainder_o (remainder),
      .div_zero_o  (div_zero),
      .overflow_o  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain signed integer division (truncates toward zero, remainder follows dividend).
   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r,
                                 output logic dz, output logic ov);
      int sa;
      int sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      dz = (sb == 0);
      ov = (sa == -128) && (sb == -1);
      if (dz) begin
         q = ALL_ONES;
         r = a;
      end else if (ov) begin
         q = MIN_VAL;
         r = 8'h00;
      end else begin
         q = 8'(sa / sb);
         r = 8'(sa % sb);
      end
   endfunction

   // Called #1 after an edge; assert start so the next edge accepts, then wait for done.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
      logic [7:0] eq, er;
      logic       edz, eov;
      int         n;
      bit         seen;
      model(a, b, eq, er, edz, eov);
      n = 0;
      while (!ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check_eq("ready_before_start", ready, 1'b1);
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      dividend = 8'($urandom); divisor = 8'($urandom);
      check_eq("ready_low_after_accept", ready, 1'b0);
      n = 0; seen = 1'b0;
      while (!seen && n < 20) begin
         if (poke && n == 3) begin
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check_eq("done_seen", seen, 1'b1);
      check_eq("latency", n, 9);
      last_done_cyc = cyc;
      check_eq("ready_with_done", ready, 1'b1);
      check_eq("quotient", quotient, eq);
      check_eq("remainder", remainder, er);
      check_eq("div_zero", div_zero, edz);
      check_eq("overflow", overflow, eov);
   endtask

   initial begin
      int         first_done;
      bit         bad_done;
      logic [7:0] ra, rb;
      reset = 1'b1; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_quot", quotient, 8'h00);
      check_eq("rst_rem", remainder, 8'h00);
      check_eq("rst_flags", {div_zero, overflow}, 2'b00);
      reset = 1'b0;
      @(posedge clk); #1;

      run_op(8'hCE, 8'h0A, 1'b0);
      run_op(8'h80, 8'hFF, 1'b0);
      run_op(8'd35, 8'hF1, 1'b0);
      run_op(8'hF9, 8'h02, 1'b0);
      run_op(8'h14, 8'h00, 1'b0);
      run_op(8'h14, 8'h0F, 1'b0);
      run_op(8'h64, 8'h07, 1'b1);

      // Back-to-back: start asserted in the done cycle of the previous op.
      run_op(8'h7F, 8'h03, 1'b0);
      first_done = last_done_cyc;
      run_op(8'h81, 8'hFD, 1'b0);
      check_eq("b2b_spacing", last_done_cyc - first_done, 10);

      // Reset in the middle of a divide.
      start = 1'b1; dividend = 8'h55; divisor = 8'h03;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("midrst_ready", ready, 1'b1);
      check_eq("midrst_done", done, 1'b0);
      check_eq("midrst_quot", quotient, 8'h00);
      check_eq("midrst_rem", remainder, 8'h00);
      check_eq("midrst_flags", {div_zero, overflow}, 2'b00);
      bad_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) bad_done = 1'b1;
      end
      check_eq("midrst_no_done", bad_done, 1'b0);
      run_op(8'h80, 8'h03, 1'b0);

      // Reset and start together: start is dropped.
      reset = 1'b1; start = 1'b1; dividend = 8'h10; divisor = 8'h02;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      check_eq("rst_start_ready", ready, 1'b1);
      check_eq("rst_start_quot", quotient, 8'h00);

      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         case ($urandom_range(0, 7))
            0: rb = 8'h00;
            1: ra = 8'h80;
            2: rb = 8'hFF;
            3: rb = 8'h80;
            default: ;
         endcase
         run_op(ra, rb, ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
